// File: rtl/fft_pkg.sv
// ----------------------------------------------------------------------------
// fft_pkg
// Shared constants and helpers used by the FFT datapath stages and by the
// output reorder buffer.
//
// Contents:
//   N, WIDTH, LOG_N  - default FFT point count, sample width, log2(N)
//   MAX_LOG_N        - largest supported log2(N) (N = 1024)
//   rd_state_t       - read-side FSM state encoding of the reorder buffer
//   bitrev()         - reverse the low 'bits' bits of an index
// ----------------------------------------------------------------------------
package fft_pkg;

    localparam int N         = 64;
    localparam int WIDTH     = 16;
    localparam int LOG_N     = $clog2(N);
    localparam int MAX_LOG_N = 10;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_t;

    // Reverse the low 'bits' bits of x; bits above that are returned as zero.
    // The loop bound is fixed so the function unrolls to pure wiring once
    // 'bits' is a constant at the call site.
    function automatic int unsigned bitrev(input int unsigned x, input int bits);
        int unsigned r;
        r = 0;
        for (int i = 0; i < MAX_LOG_N; i++) begin
            if (i < bits) begin
                r[i] = x[bits-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/reorder_ram.sv
// ----------------------------------------------------------------------------
// reorder_ram
// Simple dual-port RAM backing the two ping-pong banks of fft_reorder.
// Address is {bank, index}; one write port, one read port with a registered
// output (one cycle read latency). Contents are never cleared.
//
// Ports:
//   clock    in   master clock, rising edge
//   wr_en    in   write strobe
//   wr_addr  in   AW  write address {bank, index}
//   wr_data  in   DW  write data {re, im}
//   rd_addr  in   AW  read address {bank, index}
//   rd_data  out  DW  registered read data
// ----------------------------------------------------------------------------
module reorder_ram
    import fft_pkg::*;
#(
    parameter int AW = 7,
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fft_reorder.sv
// ----------------------------------------------------------------------------
// fft_reorder
// Converts FFT output frames from bit-reversed bin order into natural bin
// order. Two banks of N complex words are used ping-pong: a frame is written
// into one bank at address bitrev(position) while the previous frame is read
// out of the other bank sequentially.
//
// Build option:
//   FFT_REORDER_HALF_EN  when defined, only bins 0..N/2 are read out (the
//                        non-redundant half of a real-input spectrum). Write
//                        side is unchanged.
//
// Ports:
//   clock    in   master clock, rising edge
//   reset    in   synchronous active-low reset
//   di_en    in   input valid, high for N consecutive cycles per frame
//   di_re    in   WIDTH  real part, bit-reversed order
//   di_im    in   WIDTH  imag part, bit-reversed order
//   do_en    out  output valid
//   do_re    out  WIDTH  real part, natural order
//   do_im    out  WIDTH  imag part, natural order
//   do_idx   out  LOG_N  bin index of the current output sample
//   do_last  out  final sample of an output frame
//   err      out  one-cycle pulse when a partial input frame is dropped
//
// Read FSM:
//   state   | meaning
//   --------+------------------------------------------------------------
//   RD_IDLE | no full bank pending; waiting for the write side to fill one
//   RD_READ | issuing read addresses rcnt = 0..RD_LAST from bank rbank
//
// Output timing: edge E0 captures the last sample of a frame and marks the
// bank full; E1 enters RD_READ with rcnt=0; E2 registers the RAM data; E3
// registers the output, so do_en is first high after E3.
// ----------------------------------------------------------------------------
module fft_reorder
    import fft_pkg::*;
#(
    parameter int N     = fft_pkg::N,
    parameter int WIDTH = fft_pkg::WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   di_en,
    input  logic [WIDTH-1:0]       di_re,
    input  logic [WIDTH-1:0]       di_im,
    output logic                   do_en,
    output logic [WIDTH-1:0]       do_re,
    output logic [WIDTH-1:0]       do_im,
    output logic [$clog2(N)-1:0]   do_idx,
    output logic                   do_last,
    output logic                   err
);

    localparam int LOG_N = $clog2(N);
    localparam int DW    = 2 * WIDTH;
    localparam int AW    = LOG_N + 1;

    localparam logic [LOG_N-1:0] WR_LAST = LOG_N'(N - 1);
`ifdef FFT_REORDER_HALF_EN
    localparam logic [LOG_N-1:0] RD_LAST = LOG_N'(N / 2);
`else
    localparam logic [LOG_N-1:0] RD_LAST = LOG_N'(N - 1);
`endif

    // write side
    logic [LOG_N-1:0] wcnt;
    logic             wbank;
    logic [1:0]       full;
    logic [LOG_N-1:0] wr_idx;
    logic             wr_last;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;

    // read side
    rd_state_t        state;
    logic [LOG_N-1:0] rcnt;
    logic             rbank;
    logic             obank;
    logic             rd_done;
    logic [AW-1:0]    rd_addr;
    logic [DW-1:0]    rd_data;

    // RAM-read pipeline stage, aligned with rd_data
    logic             rd_valid;
    logic             rd_last_q;
    logic [LOG_N-1:0] rd_idx_q;

    assign wr_idx  = LOG_N'(bitrev(32'(wcnt), LOG_N));
    assign wr_last = di_en && (wcnt == WR_LAST);
    // di_en is ignored while reset is asserted, including the RAM write
    assign wr_en   = di_en && reset;
    assign wr_addr = {wbank, wr_idx};
    assign wr_data = {di_re, di_im};

    assign obank   = ~rbank;
    assign rd_done = (state == RD_READ) && (rcnt == RD_LAST);
    assign rd_addr = {rbank, rcnt};

    reorder_ram #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // ------------------------------------------------------------------
    // Write counter, bank toggle, full flags and partial-frame error.
    // The full flag of the bank being read is released when its last
    // address is issued; a set on the same edge takes priority.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            wcnt  <= '0;
            wbank <= 1'b0;
            full  <= 2'b00;
            err   <= 1'b0;
        end else begin
            err <= 1'b0;
            if (rd_done) begin
                full[rbank] <= 1'b0;
            end
            if (di_en) begin
                if (wcnt == WR_LAST) begin
                    wcnt        <= '0;
                    wbank       <= ~wbank;
                    full[wbank] <= 1'b1;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
            end else if (wcnt != '0) begin
                // frame broke off early: drop it and stay on the same bank
                wcnt <= '0;
                err  <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read FSM plus the RAM-read pipeline stage.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= RD_IDLE;
            rcnt      <= '0;
            rbank     <= 1'b0;
            rd_valid  <= 1'b0;
            rd_last_q <= 1'b0;
            rd_idx_q  <= '0;
        end else begin
            rd_valid  <= (state == RD_READ);
            rd_last_q <= rd_done;
            rd_idx_q  <= rcnt;
            case (state)
                RD_IDLE: begin
                    if (full != 2'b00) begin
                        state <= RD_READ;
                        rcnt  <= '0;
                        // with both banks full, the older frame sits in the
                        // bank the write pointer has wrapped back onto
                        rbank <= (full == 2'b11) ? wbank : full[1];
                    end
                end
                RD_READ: begin
                    if (rcnt == RD_LAST) begin
                        rcnt <= '0;
                        // chain straight into the other bank if it is full
                        // already or fills on this very edge
                        if (full[obank] || (wr_last && (wbank == obank))) begin
                            rbank <= obank;
                        end else begin
                            state <= RD_IDLE;
                        end
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                default: begin
                    state <= RD_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output register; data and index hold while do_en is low.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            do_en   <= 1'b0;
            do_last <= 1'b0;
            do_re   <= '0;
            do_im   <= '0;
            do_idx  <= '0;
        end else begin
            do_en   <= rd_valid;
            do_last <= rd_valid && rd_last_q;
            if (rd_valid) begin
                do_re  <= rd_data[DW-1:WIDTH];
                do_im  <= rd_data[WIDTH-1:0];
                do_idx <= rd_idx_q;
            end
        end
    end

endmodule

// File: doc/fft_reorder.md
FFT_REORDER -- requirements
Module: fft_reorder

Interface
REQ-001 SHALL have parameter N, default 64: FFT point count, power of two, 4..1024.
REQ-002 SHALL have parameter WIDTH, default 16: bit length of each real/imag sample.
REQ-003 SHALL have port clock  input  1: master clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-low reset.
REQ-005 SHALL have port di_en  input  1: input sample valid; high for N consecutive cycles per frame.
REQ-006 SHALL have port di_re  input  WIDTH: FFT output real part, bit-reversed bin order.
REQ-007 SHALL have port di_im  input  WIDTH: FFT output imag part, bit-reversed bin order.
REQ-008 SHALL have port do_en  output  1: output sample valid.
REQ-009 SHALL have port do_re  output  WIDTH: real part, natural bin order.
REQ-010 SHALL have port do_im  output  WIDTH: imag part, natural bin order.
REQ-011 SHALL have port do_idx  output  log2(N): bin index of the current output sample.
REQ-012 SHALL have port do_last  output  1: high with the final sample of an output frame.
REQ-013 SHALL have port err  output  1: one-cycle pulse when a partial input frame is discarded.

Function
REQ-014 SHALL hold two banks of N complex words (ping-pong); one bank is written while the other is read.
REQ-015 SHALL keep a write counter wcnt 0..N-1; each cycle with di_en high, write the sample to address bitrev(wcnt) in the write bank, then increment wcnt.
REQ-016 SHALL, when the sample with wcnt=N-1 is written: mark the bank full, toggle the write bank, and return wcnt to 0 on the same edge.
REQ-017 SHALL accept back-to-back frames with no idle cycle; sample 0 of the next frame goes to the new write bank.
REQ-018 SHALL, if di_en falls while 0<wcnt<N, discard the frame: wcnt to 0, no bank toggle, no read start, err high for exactly the next cycle.
REQ-019 SHALL run a read FSM with states IDLE and READ; IDLE->READ in the cycle after a bank becomes full; READ->IDLE after the last bin is issued.
REQ-020 SHALL, in READ, issue read address rcnt = 0,1,2,... from the full bank, one per cycle, with no gaps.
REQ-021 SHALL register both the RAM read and the output; latency is 3 cycles, measured from the edge that captures input sample N-1 to the first cycle with do_en high.
REQ-022 SHALL present do_idx = k with do_re/do_im equal to the input sample captured at frame position bitrev(k).
REQ-023 SHALL assert do_last together with do_en for the final bin only.
REQ-024 SHALL hold do_re, do_im and do_idx at their last values while do_en is low.
REQ-025 SHALL, if a bank becomes full in the same cycle READ ends, enter READ again with no idle cycle in the do_en stream.
REQ-026 SHALL pass data bit-exact; no arithmetic, rounding or saturation.

Reset
REQ-027 SHALL, while reset is low at a clock edge, set do_en=0, do_last=0, err=0, do_re=0, do_im=0, do_idx=0, wcnt=0, rcnt=0, write bank=0, both banks empty, FSM=IDLE.
REQ-028 SHALL abandon any frame being written or read when reset is applied mid-operation; RAM contents are not cleared.
REQ-029 SHALL ignore di_en in the reset cycle; the first frame starts at the first di_en-high cycle after reset goes high.

Configuration
REQ-030 SHALL, with FFT_REORDER_HALF_EN defined, output only bins 0..N/2 (N/2+1 samples, do_last at do_idx=N/2) for real-input spectra.
REQ-031 SHALL, without FFT_REORDER_HALF_EN, output all N bins (do_last at do_idx=N-1); write behaviour is identical in both modes.

Structure
REQ-032 SHALL take N, WIDTH, LOG_N and the bitrev function from shared package fft_pkg, which the FFT stages also use.
REQ-033 SHALL implement storage in one sub-module, reorder_ram: a 2*N x 2*WIDTH simple dual-port RAM with a registered read port, address = {bank, index}.

Verification
REQ-034 SHALL cover: N=64, one frame di_re=position p, di_im=-p -> 64 outputs, do_idx=k carries di_re=bitrev6(k) (k=1 -> 32, k=2 -> 16), do_last at k=63, first do_en 3 cycles after last input.
REQ-035 SHALL cover: 3 back-to-back frames with offsets 0/100/200 -> 192 contiguous do_en cycles, do_last at cycles 63/127/191, values correct per frame.
REQ-036 SHALL cover: di_en drops after 20 samples, then a full frame -> err one cycle, no output for the partial frame, full frame output correct.
REQ-037 SHALL cover: reset low for 1 cycle at output bin 30 -> all outputs 0 next cycle, no further do_en until a new full frame.
REQ-038 SHALL cover: FFT_REORDER_HALF_EN, one frame -> 33 outputs, do_idx 0..32, do_last at 32.
REQ-039 SHALL cover: N=4 minimum size, frame 10,11,12,13 -> do_re 10,12,11,13.
